// File: rtl/uart_port_if.sv
// CPU-side handshake bundle for uart_port: byte write strobe/ready and held read request/ack.
interface uart_port_if;
  logic       uartWriteReq;
  logic [7:0] uartWriteData;
  logic       uartWriteReady;
  logic       uartReadReq;
  logic       uartReadAck;
  logic [7:0] uartReadData;

  modport master (
    output uartWriteReq, uartWriteData, uartReadReq,
    input  uartWriteReady, uartReadAck, uartReadData
  );

  modport slave (
    input  uartWriteReq, uartWriteData, uartReadReq,
    output uartWriteReady, uartReadAck, uartReadData
  );
endinterface

// File: rtl/uart_port.sv
// 8N1 UART endpoint: CPU write handshake -> txd serialiser, rxd deserialiser -> RX FIFO -> CPU read handshake.
module uart_port #(
  parameter int CLKS_PER_BIT = 4,
  parameter int RX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  uart_port_if.slave cpu,
  output logic       txd,
  input  logic       rxd,
  output logic       rxOverflow,
  output logic       rxFrameErr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------- TX ----------------
  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_txd_q, tx_txd_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_txd_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_txd_q   <= tx_txd_d;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_txd_d   = tx_txd_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (cpu.uartWriteReq) begin
          tx_shift_d = cpu.uartWriteData;
          tx_state_d = S_START;
          tx_txd_d   = 1'b0;
        end
      end
      S_START: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_txd_d   = tx_shift_q[0];
      end
      S_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP;
          tx_txd_d   = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_txd_d   = tx_shift_q[1];
        end
      end
      S_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign txd                = tx_txd_q;
  assign cpu.uartWriteReady = (tx_state_q == S_IDLE);

  // ---------------- RX ----------------
  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_push, rx_bad_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Start bit is re-checked at mid-bit; every later sample is one full bit period apart.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CW'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    rx_bad_stop = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == BIT_HALF) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rxd_sync_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      S_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_state_d  = S_IDLE;
        rx_cnt_d    = '0;
        rx_push     = rxd_sync_q;
        rx_bad_stop = !rxd_sync_q;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO and read handshake ----------------
  logic [7:0]  fifo_mem [RX_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_full, fifo_empty, do_push, do_pop;
  logic        armed_q, ack_q, ovf_q, ferr_q;
  logic [7:0]  rdata_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push    = rx_push && !fifo_full;
  assign do_pop     = cpu.uartReadReq && armed_q && !fifo_empty;

  // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      armed_q  <= 1'b1;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ack_q  <= do_pop;
      ovf_q  <= ovf_q | (rx_push & fifo_full);
      ferr_q <= ferr_q | rx_bad_stop;
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        rdata_q  <= fifo_mem[rd_ptr_q[AW-1:0]];
        armed_q  <= 1'b0;
      end else if (!cpu.uartReadReq) begin
        armed_q  <= 1'b1;
      end
    end
  end

  assign cpu.uartReadAck  = ack_q;
  assign cpu.uartReadData = rdata_q;
  assign rxOverflow       = ovf_q;
  assign rxFrameErr       = ferr_q;
endmodule

// File: doc/uart_port.md
# uart_port

Byte-serial UART endpoint between the CPU's UART handshake ports and the physical serial pins. The CPU hands bytes to it through the write handshake and collects received bytes through the read handshake; the block serialises and deserialises 8N1 frames on `txd`/`rxd`. Received bytes are buffered in a small FIFO so the CPU may poll late without losing data.

## Interface
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; integer ≥ 4, even.
- `RX_DEPTH`, 4, RX FIFO entries; power of two ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `uartWriteReq`  in  1  CPU write strobe; one-cycle pulse.
- `uartWriteData`  in  8  byte to transmit, valid with `uartWriteReq`.
- `uartWriteReady`  out  1  high when a write will be accepted.
- `uartReadReq`  in  1  CPU read request; level, held until ack.
- `uartReadAck`  out  1  one-cycle pulse; `uartReadData` valid this cycle.
- `uartReadData`  out  8  received byte.
- `txd`  out  1  serial output, idle high.
- `rxd`  in  1  serial input, asynchronous to `clk`.
- `rxOverflow`  out  1  sticky: byte dropped because FIFO full.
- `rxFrameErr`  out  1  sticky: stop bit sampled low.

## Operation
- Reset values: `uartWriteReady`=1, `uartReadAck`=0, `uartReadData`=0, `txd`=1, `rxOverflow`=0, `rxFrameErr`=0; FIFO empty; both FSMs idle. Sticky flags clear only on reset.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `uartWriteReq`=1 while `uartWriteReady`=1 latches the byte and enters START. A request while ready=0 is ignored; no queueing.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- RX: `rxd` passes through a 2-flop synchroniser (fixed 2-cycle delay). FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronised falling edge enters START.
  - START: sample at `CLKS_PER_BIT/2`. If the sample is high, treat it as a glitch and return to IDLE with no byte.
  - DATA: sample each bit at mid-bit, spaced `CLKS_PER_BIT` apart, LSB first.
  - STOP: sample at mid-bit. High → push byte to FIFO. Low → discard byte and set `rxFrameErr`. Return to IDLE immediately after the stop sample, so back-to-back frames are received.
  - Push while FIFO full: byte dropped, FIFO unchanged, `rxOverflow`=1.
- Read handshake: the block pulses `uartReadAck` for exactly one cycle when `uartReadReq`=1, FIFO non-empty, and the request is armed. The same edge drives `uartReadData` with the FIFO head and pops it.
  - The ack disarms the request. It re-arms after `uartReadReq` is sampled low for at least one cycle, so one request yields one byte.
  - FIFO empty: request stays pending; ack follows the first cycle a byte is present.
  - `uartReadData` holds its last value between acks.
- Simultaneous push and pop in one cycle are both performed; occupancy is unchanged. Push when full is dropped even if a pop occurs the same cycle.
- FIFO pointers are `log2(RX_DEPTH)+1` bits wide with natural wrap; full/empty come from MSB comparison.

## Timing
- Write accepted at edge N: `uartWriteReady`=0 and `txd`=0 from edge N+1.
- Frame is `10*CLKS_PER_BIT` cycles. `uartWriteReady` returns to 1 on the edge ending STOP. The earliest next write is accepted that cycle, giving back-to-back frames with no idle gap.
- RX latency: the byte enters the FIFO 2 (sync) + 1 (edge detect) + `9.5*CLKS_PER_BIT` cycles after the `rxd` falling edge.
- Read: ack is registered, asserted the cycle after the req-and-data condition first holds. Minimum 1-cycle latency; minimum 2 cycles between acks to one held-then-dropped request.
- Reset mid-frame: within the same cycle `txd` forces to 1, `uartWriteReady` forces to 1, and any partial RX byte is discarded.

## Test plan
- Write 0xA5 with `CLKS_PER_BIT`=4 -> `txd` shows 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles; ready low for 40 cycles, then high.
- Loopback (`txd`→`rxd`): write 0x3C, hold `uartReadReq` -> single `uartReadAck` with `uartReadData`=0x3C; a second request while the FIFO is empty gets no ack.
- Loopback 5 bytes 0x01..0x05 with no reads -> `rxOverflow`=1; four reads return 0x01..0x04; a fifth request is not acked.
- Drive a frame for 0x7E with the stop bit low -> `rxFrameErr`=1, FIFO stays empty; the following valid frame 0x11 is received correctly.
- `rxd` low pulse of 1 cycle -> no byte, no error flags.
- Assert `reset` in the DATA phase of a TX frame of 0xFF -> `txd`=1 and ready=1 immediately; after release, writing 0x42 produces a clean frame.
